if_sequencer: RTL and testbench
===============================

IF_SEQUENCER -- requirements
Module: if_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  RESET_PC  32'h0000_0000  PC loaded on reset
  PC_STEP  4  sequential PC increment in bytes
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  input  1  single clock; all state updates on rising edge
  rst  input  1  synchronous reset, active-high
  imem_req_valid  output  1  fetch request to instruction memory
  imem_req_ready  input  1  memory accepts request this cycle
  imem_req_addr  output  32  fetch address; bits [1:0] always 0
  imem_rsp_valid  input  1  response data valid
  imem_rsp_data  input  32  fetched instruction word
  redirect_valid  input  1  branch/jump redirect, one-cycle pulse or level
  redirect_pc  input  32  redirect target
  if_valid  output  1  instruction available to decode
  if_ready  input  1  decode accepts instruction
  if_instr  output  32  instruction word
  if_pc  output  32  PC of if_instr
REQ-003 The block SHALL use one clock (clk); reset SHALL be synchronous and active-high (rst).

Function
REQ-004 FSM states SHALL be IDLE, REQ, WAIT, HOLD, DROP; at most one imem request outstanding.
REQ-005 IDLE: no request; next cycle -> REQ.
REQ-006 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> WAIT, latch req_pc=pc, pc <= pc+PC_STEP.
REQ-007 WAIT: on imem_rsp_valid, register if_instr=imem_rsp_data, if_pc=req_pc, if_valid=1 next cycle; -> HOLD.
REQ-008 HOLD: if_valid=1; if_valid/if_instr/if_pc SHALL stay stable until if_ready; on if_valid&&if_ready -> REQ, if_valid=0 next cycle.
REQ-009 Latency: response-to-if_valid 1 cycle; with 1-cycle memory and if_ready held high, a new request SHALL issue every 3 cycles (REQ, WAIT, HOLD).
REQ-010 Redirect SHALL have highest priority over every other event in the same cycle; redirect_pc[1:0] forced to 0.
REQ-011 Redirect in IDLE, HOLD, or REQ without imem_req_ready: pc <= redirect_pc, if_valid <= 0, -> REQ; withdrawing an unaccepted request is permitted.
REQ-012 Redirect in REQ with imem_req_ready, or in WAIT without imem_rsp_valid: pc <= redirect_pc, -> DROP.
REQ-013 Redirect in WAIT with imem_rsp_valid: response discarded, pc <= redirect_pc, -> REQ.
REQ-014 DROP: imem_req_valid=0, if_valid=0; on imem_rsp_valid discard data, -> REQ; redirect in DROP updates pc, stays DROP unless rsp arrives same cycle (then -> REQ).
REQ-015 imem_rsp_valid outside WAIT/DROP SHALL be ignored.
REQ-016 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-017 if_ready while if_valid=0 SHALL have no effect.

Reset
REQ-018 On rst=1 at a clock edge: state=IDLE, pc=RESET_PC, req_pc=0, if_valid=0, if_instr=0, if_pc=0, imem_req_valid=0, imem_req_addr=0.
REQ-019 rst SHALL override redirect and all handshakes; reset mid-request abandons it (imem shares rst, no stale response expected).
REQ-020 First request SHALL assert the second cycle after rst deasserts (IDLE then REQ).

Structure
REQ-021 Package if_pkg SHALL hold the state enum, XLEN=32, default RESET_PC and PC_STEP.
REQ-022 One sub-module if_pc_gen SHALL implement the next-PC mux (reset / redirect / +PC_STEP / hold); FSM and output registers stay in if_sequencer.

Verification
REQ-023 Reset release, 1-cycle memory, if_ready=1 -> requests at 0x0, 0x4, 0x8 spaced 3 cycles; if_pc matches, if_instr equals returned data.
REQ-024 if_ready=0 for 5 cycles in HOLD -> if_valid, if_instr, if_pc unchanged; no new request until handshake.
REQ-025 Redirect to 0x100 in WAIT, response 2 cycles later -> response dropped, if_valid never asserts with it; next request addr 0x100.
REQ-026 Redirect to 0x203 coincident with imem_rsp_valid in WAIT -> data discarded, next request addr 0x200.
REQ-027 Redirect while REQ stalled (imem_req_ready=0) -> imem_req_addr changes to target next cycle, no DROP entered.
REQ-028 RESET_PC=32'hFFFF_FFFC, two fetches -> addresses 0xFFFF_FFFC then 0x0000_0000; rst asserted in WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/if_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_pkg : shared types and defaults for the instruction-fetch sequencer
// rev 1.0
// ---------------------------------------------------------------------------
package if_pkg;

   localparam int              XLEN             = 32;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int              DEFAULT_PC_STEP  = 4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      HOLD = 3'd3,
      DROP = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/if_pc_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_pc_gen : fetch PC register with reset / redirect / step / hold mux
// rev 1.0
// ---------------------------------------------------------------------------
module if_pc_gen
   import if_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              PC_STEP  = DEFAULT_PC_STEP
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_pc,
   input  logic            i_advance,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_pc_next
);

   localparam logic [XLEN-1:0] c_step = XLEN'(PC_STEP);

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_next;

   // Redirect outranks the sequential step; targets are word-aligned.
   always_comb begin
      w_pc_next = r_pc;
      if (rst)
         w_pc_next = RESET_PC;
      else if (i_redirect_valid)
         w_pc_next = {i_redirect_pc[XLEN-1:2], 2'b00};
      else if (i_advance)
         w_pc_next = r_pc + c_step;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_pc <= RESET_PC;
      else
         r_pc <= w_pc_next;
   end

   assign o_pc      = r_pc;
   assign o_pc_next = w_pc_next;

endmodule
`default_nettype wire

// File: rtl/if_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_sequencer : instruction-fetch sequencer, at most one fetch in flight
// rev 1.0
// ---------------------------------------------------------------------------
module if_sequencer
   import if_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              PC_STEP  = DEFAULT_PC_STEP
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);

   state_t          r_state;
   logic            r_req_valid;
   logic [XLEN-1:0] r_req_addr;
   logic [XLEN-1:0] r_req_pc;
   logic            r_if_valid;
   logic [XLEN-1:0] r_if_instr;
   logic [XLEN-1:0] r_if_pc;
   logic [XLEN-1:0] w_pc;
   logic [XLEN-1:0] w_pc_next;
   logic            w_advance;

   assign w_advance = (r_state == REQ) && imem_req_ready;

   if_pc_gen #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc_gen (
      .clk              (clk),
      .rst              (rst),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc),
      .i_advance        (w_advance),
      .o_pc             (w_pc),
      .o_pc_next        (w_pc_next)
   );

   // Request outputs are registered: every path into REQ loads the PC it
   // will present, which is always next cycle's PC.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_req_valid <= 1'b0;
         r_req_addr  <= '0;
         r_req_pc    <= '0;
         r_if_valid  <= 1'b0;
         r_if_instr  <= '0;
         r_if_pc     <= '0;
      end else begin
         r_req_valid <= 1'b0;
         r_req_addr  <= '0;
         case (r_state)
            IDLE: begin
               r_state     <= REQ;
               r_req_valid <= 1'b1;
               r_req_addr  <= w_pc_next;
            end
            REQ: begin
               if (imem_req_ready) begin
                  r_state  <= redirect_valid ? DROP : WAIT;
                  r_req_pc <= w_pc;
               end else begin
                  r_state     <= REQ;
                  r_req_valid <= 1'b1;
                  r_req_addr  <= w_pc_next;
               end
            end
            WAIT: begin
               if (redirect_valid && imem_rsp_valid) begin
                  r_state     <= REQ;
                  r_req_valid <= 1'b1;
                  r_req_addr  <= w_pc_next;
               end else if (redirect_valid) begin
                  r_state <= DROP;
               end else if (imem_rsp_valid) begin
                  r_state    <= HOLD;
                  r_if_valid <= 1'b1;
                  r_if_instr <= imem_rsp_data;
                  r_if_pc    <= r_req_pc;
               end
            end
            HOLD: begin
               if (redirect_valid || if_ready) begin
                  r_state     <= REQ;
                  r_if_valid  <= 1'b0;
                  r_req_valid <= 1'b1;
                  r_req_addr  <= w_pc_next;
               end
            end
            DROP: begin
               // The orphaned response must land before a new fetch goes out.
               if (imem_rsp_valid) begin
                  r_state     <= REQ;
                  r_req_valid <= 1'b1;
                  r_req_addr  <= w_pc_next;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_if_valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req_valid = r_req_valid;
   assign imem_req_addr  = r_req_addr;
   assign if_valid       = r_if_valid;
   assign if_instr       = r_if_instr;
   assign if_pc          = r_if_pc;

endmodule
`default_nettype wire

// File: tb/tb_if_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_if_sequencer : scoreboard bench for if_sequencer
// rev 1.0
// ---------------------------------------------------------------------------
module tb_if_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc    = 32'h0;
   logic        if_valid;
   logic        if_ready = 1'b1;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   logic        rst2 = 1'b1;
   logic        req2_valid;
   logic [31:0] req2_addr;
   logic        rsp2_valid = 1'b0;
   logic [31:0] rsp2_data  = 32'h0;
   logic        if2_valid;
   logic [31:0] if2_instr;
   logic [31:0] if2_pc;
   logic        acc2 = 1'b0;
   logic [31:0] acc2_addr = 32'h0;

   int          total = 0;
   int          bad   = 0;
   int          acc_cnt = 0;
   int          cyc = 0;
   int          last_acc = -1;
   bit          spacing_on = 1'b1;
   int          mem_lat = 1;
   int          pend_cnt = 0;
   logic [31:0] pend_data = 32'h0;
   logic [63:0] sb_q[$];
   logic [31:0] addr_q[$];

   always #5 clk = ~clk;

   if_sequencer u_dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc)
   );

   if_sequencer #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) u_dut2 (
      .clk            (clk),
      .rst            (rst2),
      .imem_req_valid (req2_valid),
      .imem_req_ready (1'b1),
      .imem_req_addr  (req2_addr),
      .imem_rsp_valid (rsp2_valid),
      .imem_rsp_data  (rsp2_data),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .if_valid       (if2_valid),
      .if_ready       (1'b1),
      .if_instr       (if2_instr),
      .if_pc          (if2_pc)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      total++;
      bad++;
      $display("FAIL %s: event seen with nothing expected", name);
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   // Memory model: responds mem_lat cycles after an accepted request.
   initial forever begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      if (pend_cnt > 0) begin
         pend_cnt = pend_cnt - 1;
         if (pend_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend_data;
         end
      end
      #1;
      if (rst) pend_cnt = 0;
      else if (imem_req_valid && imem_req_ready) begin
         pend_cnt  = mem_lat;
         pend_data = 32'hC0DE_0000 + imem_req_addr;
      end
   end

   // One-cycle memory for the wrap-around instance.
   initial forever begin
      @(negedge clk);
      rsp2_valid = acc2;
      rsp2_data  = 32'hC0DE_0000 + acc2_addr;
      #1;
      acc2      = !rst2 && req2_valid;
      acc2_addr = req2_addr;
   end

   // Request monitor: address order and issue spacing.
   initial forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst && imem_req_valid && imem_req_ready) begin
         if (addr_q.size() == 0) unexpected("req_addr");
         else chk("req_addr", imem_req_addr, addr_q.pop_front());
         if (spacing_on && last_acc >= 0) chk("req_spacing", 32'(cyc - last_acc), 32'd3);
         last_acc = cyc;
         acc_cnt++;
      end
   end

   // Decode-side monitor: every handshake must match the scoreboard head.
   initial forever begin
      logic [63:0] e;
      @(negedge clk);
      #1;
      if (!rst && if_valid && if_ready) begin
         if (sb_q.size() == 0) unexpected("if_out");
         else begin
            e = sb_q.pop_front();
            chk("if_pc", if_pc, e[63:32]);
            chk("if_instr", if_instr, e[31:0]);
         end
      end
   end

   task automatic fetch_one(input logic [31:0] a, input logic [31:0] d);
      int c0;
      c0 = acc_cnt;
      addr_q.push_back(a);
      sb_q.push_back({a, d});
      imem_req_ready = 1'b1;
      for (int k = 0; k < 20 && acc_cnt == c0; k++) tick();
      imem_req_ready = 1'b0;
      chk("fetch_accept", 32'(acc_cnt), 32'(c0 + 1));
      for (int k = 0; k < 20 && sb_q.size() != 0; k++) tick();
      chk("fetch_done", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      imem_req_ready = 1'b1;
      repeat (3) tick();
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_req_addr", imem_req_addr, 32'd0);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_if_instr", if_instr, 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);

      // Back-to-back fetches with a one-cycle memory.
      addr_q.push_back(32'h0); sb_q.push_back({32'h0, 32'hC0DE_0000});
      addr_q.push_back(32'h4); sb_q.push_back({32'h4, 32'hC0DE_0004});
      addr_q.push_back(32'h8); sb_q.push_back({32'h8, 32'hC0DE_0008});
      rst = 1'b0;
      tick();
      chk("first_req_valid", 32'(imem_req_valid), 32'd1);
      chk("first_req_addr", imem_req_addr, 32'h0);
      for (int k = 0; k < 30 && acc_cnt < 3; k++) tick();
      imem_req_ready = 1'b0;
      spacing_on = 1'b0;
      chk("three_reqs", 32'(acc_cnt), 32'd3);
      for (int k = 0; k < 20 && sb_q.size() != 0; k++) tick();
      chk("three_done", 32'(sb_q.size()), 32'd0);

      // Decode stall in HOLD.
      if_ready = 1'b0;
      addr_q.push_back(32'hC); sb_q.push_back({32'hC, 32'hC0DE_000C});
      imem_req_ready = 1'b1;
      for (int k = 0; k < 20 && acc_cnt < 4; k++) tick();
      imem_req_ready = 1'b0;
      for (int k = 0; k < 20 && !if_valid; k++) tick();
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("hold_valid", 32'(if_valid), 32'd1);
         chk("hold_pc", if_pc, 32'hC);
         chk("hold_instr", if_instr, 32'hC0DE_000C);
         chk("hold_noreq", 32'(imem_req_valid), 32'd0);
      end
      if_ready = 1'b1;
      for (int k = 0; k < 20 && sb_q.size() != 0; k++) tick();
      chk("hold_done", 32'(sb_q.size()), 32'd0);

      // Redirect in WAIT, response arrives later and must be dropped.
      addr_q.push_back(32'h10);
      mem_lat = 3;
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      redirect_valid = 1'b0;
      chk("drop_noreq", 32'(imem_req_valid), 32'd0);
      chk("drop_noif", 32'(if_valid), 32'd0);
      tick();
      chk("drop_wait", 32'(imem_req_valid), 32'd0);
      tick();
      chk("drop_exit_valid", 32'(imem_req_valid), 32'd1);
      chk("drop_exit_addr", imem_req_addr, 32'h100);
      mem_lat = 1;
      fetch_one(32'h100, 32'hC0DE_0100);

      // Redirect coincident with the response in WAIT, misaligned target.
      addr_q.push_back(32'h104);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      tick();
      redirect_valid = 1'b0;
      chk("coinc_req_valid", 32'(imem_req_valid), 32'd1);
      chk("coinc_req_addr", imem_req_addr, 32'h200);
      chk("coinc_noif", 32'(if_valid), 32'd0);
      fetch_one(32'h200, 32'hC0DE_0200);

      // Redirect while the request is stalled.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      tick();
      redirect_valid = 1'b0;
      chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
      chk("stall_req_addr", imem_req_addr, 32'h300);
      tick();
      chk("stall_no_drop", 32'(imem_req_valid), 32'd1);
      fetch_one(32'h300, 32'hC0DE_0300);

      // Wrap-around instance, then reset in WAIT.
      rst2 = 1'b0;
      for (int k = 0; k < 10 && !req2_valid; k++) tick();
      chk("wrap_req0_valid", 32'(req2_valid), 32'd1);
      chk("wrap_req0_addr", req2_addr, 32'hFFFF_FFFC);
      for (int k = 0; k < 10 && !if2_valid; k++) tick();
      chk("wrap_if_pc", if2_pc, 32'hFFFF_FFFC);
      chk("wrap_if_instr", if2_instr, 32'hC0DD_FFFC);
      for (int k = 0; k < 10 && !req2_valid; k++) tick();
      chk("wrap_req1_addr", req2_addr, 32'h0);
      tick();
      rst2 = 1'b1;
      tick();
      chk("rst2_req_valid", 32'(req2_valid), 32'd0);
      chk("rst2_req_addr", req2_addr, 32'd0);
      chk("rst2_if_valid", 32'(if2_valid), 32'd0);
      chk("rst2_if_instr", if2_instr, 32'd0);
      chk("rst2_if_pc", if2_pc, 32'd0);

      chk("sb_left", 32'(sb_q.size()), 32'd0);
      chk("addr_left", 32'(addr_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
